// File: rtl/apb_vgachargen_bridge.sv
// APB4 completer driving vgachargen's char_map, col_map and char_tiff memory ports.
// Optional: define VGACHARGEN_APB_RANGE_CHECK_EN to reject map accesses beyond MAP_WORDS.
module apb_vgachargen_bridge #(
  parameter int APB_ADDR_W = 14,
  parameter int MEM_ADDR_W = 10,
  parameter int MAP_WORDS  = 600
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [APB_ADDR_W-1:0] paddr_i,
  input  logic [31:0]           pwdata_i,
  input  logic [3:0]            pstrb_i,
  output logic [31:0]           prdata_o,
  output logic                  pready_o,
  output logic                  pslverr_o,
  output logic [MEM_ADDR_W-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic [3:0]            mem_be_o,
  output logic                  char_map_we_o,
  output logic                  col_map_we_o,
  output logic                  char_tiff_we_o,
  input  logic [31:0]           char_map_rdata_i,
  input  logic [31:0]           col_map_rdata_i,
  input  logic [31:0]           char_tiff_rdata_i
);

`ifdef VGACHARGEN_APB_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif
  localparam logic [MEM_ADDR_W-1:0] MAP_LIMIT = MEM_ADDR_W'(MAP_WORDS);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

  state_t                state_q, state_d;
  logic [1:0]            region_q;
  logic                  wr_q;
  logic                  err_q;
  logic                  setup;
  logic [1:0]            region_in;
  logic [MEM_ADDR_W-1:0] word_in;
  logic                  err_in;
  logic [31:0]           rdata_sel;
  logic                  unused_addr_lsb;

  assign unused_addr_lsb = ^paddr_i[1:0];
  assign setup           = (state_q == IDLE) && psel_i && !penable_i;

  always_comb begin
    region_in = paddr_i[APB_ADDR_W-1 -: 2];
    word_in   = paddr_i[MEM_ADDR_W+1:2];
    err_in    = 1'b0;
    if (region_in == 2'd3)
      err_in = 1'b1;
    if (region_in == 2'd2 && pwrite_i && pstrb_i != 4'hF)
      err_in = 1'b1;
    if (RANGE_CHECK && !region_in[1] && word_in >= MAP_LIMIT)
      err_in = 1'b1;
  end

  always_comb begin
    rdata_sel = char_tiff_rdata_i;
    case (region_q)
      2'd0:    rdata_sel = char_map_rdata_i;
      2'd1:    rdata_sel = col_map_rdata_i;
      default: rdata_sel = char_tiff_rdata_i;
    endcase
  end

  // Dropping psel_i at any point after setup abandons the transfer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (setup) state_d = ISSUE;
      ISSUE:   if (!psel_i) state_d = IDLE;
               else if (wr_q || err_q) state_d = DONE;
               else state_d = CAPTURE;
      CAPTURE: state_d = psel_i ? DONE : IDLE;
      DONE:    if (!psel_i || penable_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Write strobes are set at the setup edge so they are high for exactly the ISSUE cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      region_q       <= 2'd0;
      wr_q           <= 1'b0;
      err_q          <= 1'b0;
      mem_addr_o     <= '0;
      mem_wdata_o    <= 32'd0;
      mem_be_o       <= 4'd0;
      char_map_we_o  <= 1'b0;
      col_map_we_o   <= 1'b0;
      char_tiff_we_o <= 1'b0;
      prdata_o       <= 32'd0;
    end else begin
      char_map_we_o  <= 1'b0;
      col_map_we_o   <= 1'b0;
      char_tiff_we_o <= 1'b0;
      if (setup) begin
        region_q    <= region_in;
        wr_q        <= pwrite_i;
        err_q       <= err_in;
        mem_addr_o  <= word_in;
        mem_wdata_o <= pwdata_i;
        mem_be_o    <= pwrite_i ? pstrb_i : 4'd0;
        if (pwrite_i && !err_in) begin
          char_map_we_o  <= (region_in == 2'd0);
          col_map_we_o   <= (region_in == 2'd1);
          char_tiff_we_o <= (region_in == 2'd2);
        end
      end
      if (state_q == ISSUE && err_q)
        prdata_o <= 32'd0;
      if (state_q == CAPTURE)
        prdata_o <= rdata_sel;
    end
  end

  assign pready_o  = (state_q == DONE);
  assign pslverr_o = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_apb_vgachargen_bridge.sv
// Directed testbench for apb_vgachargen_bridge with a behavioural model of the three memories.
module tb_apb_vgachargen_bridge;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        psel_i, penable_i, pwrite_i;
  logic [13:0] paddr_i;
  logic [31:0] pwdata_i;
  logic [3:0]  pstrb_i;
  logic [31:0] prdata_o;
  logic        pready_o, pslverr_o;
  logic [9:0]  mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        char_map_we_o, col_map_we_o, char_tiff_we_o;
  logic [31:0] char_map_rdata_i, col_map_rdata_i, char_tiff_rdata_i;

  int errors = 0;
  int checks = 0;

  int         map_we_cnt = 0, col_we_cnt = 0, tiff_we_cnt = 0;
  logic [9:0] last_addr = '0;
  logic [3:0] last_be = '0;

  logic [31:0] char_mem [1024];
  logic [31:0] col_mem  [1024];
  logic [31:0] tiff_mem [1024];

  apb_vgachargen_bridge dut (
    .clk_i(clk_i), .rst_i(rst_i), .psel_i(psel_i), .penable_i(penable_i),
    .pwrite_i(pwrite_i), .paddr_i(paddr_i), .pwdata_i(pwdata_i), .pstrb_i(pstrb_i),
    .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .char_map_we_o(char_map_we_o), .col_map_we_o(col_map_we_o),
    .char_tiff_we_o(char_tiff_we_o), .char_map_rdata_i(char_map_rdata_i),
    .col_map_rdata_i(col_map_rdata_i), .char_tiff_rdata_i(char_tiff_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Synchronous memories: byte-enabled writes on the maps, 1-cycle registered read data.
  always @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (char_map_we_o && mem_be_o[b]) char_mem[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      if (col_map_we_o && mem_be_o[b])  col_mem[mem_addr_o][8*b +: 8]  <= mem_wdata_o[8*b +: 8];
    end
    if (char_tiff_we_o) tiff_mem[mem_addr_o] <= mem_wdata_o;
    char_map_rdata_i  <= char_mem[mem_addr_o];
    col_map_rdata_i   <= col_mem[mem_addr_o];
    char_tiff_rdata_i <= tiff_mem[mem_addr_o];
  end

  always @(negedge clk_i) begin
    if (char_map_we_o) begin map_we_cnt++; last_addr = mem_addr_o; last_be = mem_be_o; end
    if (col_map_we_o)  col_we_cnt++;
    if (char_tiff_we_o) tiff_we_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete APB transfer; waits counts wait states seen before pready_o.
  task automatic applyStimulus(input logic wr, input logic [13:0] addr, input logic [31:0] wd,
                               input logic [3:0] strb, output logic [31:0] rd,
                               output logic err, output int waits);
    @(posedge clk_i); #1;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr;
    paddr_i = addr; pwdata_i = wd; pstrb_i = strb;
    @(posedge clk_i); #1;
    penable_i = 1'b1;
    waits = 0;
    while (!pready_o && waits < 20) begin
      @(posedge clk_i); #1;
      waits++;
    end
    if (!pready_o) checkOutput("pready_timeout", 32'd0, 32'd1);
    rd  = prdata_o;
    err = pslverr_o;
    @(posedge clk_i); #1;
    psel_i = 1'b0; penable_i = 1'b0;
  endtask

  initial begin
    logic [31:0] rd, pat;
    logic        err;
    int          waits, m0, c0, t0, bad, bad_err, seen;

    rst_i = 1'b0; psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    paddr_i = '0; pwdata_i = '0; pstrb_i = '0;

    #100;
    checkOutput("rst_prdata", prdata_o, 32'd0);
    checkOutput("rst_flags", {29'd0, pready_o, pslverr_o, char_map_we_o | col_map_we_o | char_tiff_we_o}, 32'd0);
    checkOutput("rst_mem_bus", {mem_addr_o, mem_be_o} | mem_wdata_o, 32'd0);
    #3 rst_i = 1'b1;
    repeat (5) @(posedge clk_i);
    #1 checkOutput("idle_no_we", map_we_cnt + col_we_cnt + tiff_we_cnt, 32'd0);

    // Byte-enabled char_map write on top of a zeroed word.
    applyStimulus(1'b1, 14'h0008, 32'h0, 4'hF, rd, err, waits);
    m0 = map_we_cnt;
    applyStimulus(1'b1, 14'h0008, 32'hDEADBEEF, 4'h3, rd, err, waits);
    checkOutput("wr_waits", waits, 32'd1);
    checkOutput("wr_err", err, 32'd0);
    checkOutput("wr_pulse", map_we_cnt - m0, 32'd1);
    checkOutput("wr_addr", last_addr, 32'd2);
    checkOutput("wr_be", last_be, 32'h3);
    applyStimulus(1'b0, 14'h0008, 32'h0, 4'hF, rd, err, waits);
    checkOutput("rd_char_be", rd, 32'h0000BEEF);
    checkOutput("rd_be_zero", mem_be_o, 32'd0);

    applyStimulus(1'b1, 14'h1004, 32'h04040404, 4'hF, rd, err, waits);
    applyStimulus(1'b0, 14'h1004, 32'h0, 4'h0, rd, err, waits);
    checkOutput("rd_col_data", rd, 32'h04040404);
    checkOutput("rd_col_waits", waits, 32'd2);
    checkOutput("rd_col_err", err, 32'd0);

    t0 = tiff_we_cnt;
    applyStimulus(1'b1, 14'h2000, 32'h12345678, 4'h7, rd, err, waits);
    checkOutput("tiff_strb_err", err, 32'd1);
    checkOutput("tiff_strb_nowe", tiff_we_cnt - t0, 32'd0);
    applyStimulus(1'b0, 14'h3000, 32'h0, 4'h0, rd, err, waits);
    checkOutput("reg3_err", err, 32'd1);
    checkOutput("reg3_rdata", rd, 32'd0);
    checkOutput("reg3_waits", waits, 32'd1);

    applyStimulus(1'b1, 14'h095C, 32'h11223344, 4'hF, rd, err, waits);
    applyStimulus(1'b0, 14'h095C, 32'h0, 4'h0, rd, err, waits);
    checkOutput("w599_data", rd, 32'h11223344);
    checkOutput("w599_err", err, 32'd0);
    m0 = map_we_cnt;
    applyStimulus(1'b1, 14'h0960, 32'hCAFEF00D, 4'hF, rd, err, waits);
`ifdef VGACHARGEN_APB_RANGE_CHECK_EN
    checkOutput("w600_wr_err", err, 32'd1);
    checkOutput("w600_nowe", map_we_cnt - m0, 32'd0);
    applyStimulus(1'b0, 14'h0960, 32'h0, 4'h0, rd, err, waits);
    checkOutput("w600_rd_err", err, 32'd1);
    checkOutput("w600_rdata", rd, 32'd0);
`else
    checkOutput("w600_wr_err", err, 32'd0);
    checkOutput("w600_we", map_we_cnt - m0, 32'd1);
    applyStimulus(1'b0, 14'h0960, 32'h0, 4'h0, rd, err, waits);
    checkOutput("w600_rd_err", err, 32'd0);
    checkOutput("w600_rdata", rd, 32'hCAFEF00D);
`endif

    // Fill every char_tiff word before reading any back so address aliasing shows up.
    for (int i = 0; i < 1024; i++) begin
      pat = {16'(i) ^ 16'h5A5A, 16'(i)};
      applyStimulus(1'b1, 14'h2000 | 14'(i << 2), pat, 4'hF, rd, err, waits);
    end
    bad = 0; bad_err = 0;
    for (int i = 0; i < 1024; i++) begin
      pat = {16'(i) ^ 16'h5A5A, 16'(i)};
      applyStimulus(1'b0, 14'h2000 | 14'(i << 2), 32'h0, 4'h0, rd, err, waits);
      if (rd !== pat) bad++;
      if (err !== 1'b0) bad_err++;
    end
    checkOutput("tiff_sweep_data", bad, 32'd0);
    checkOutput("tiff_sweep_err", bad_err, 32'd0);

    // Abort a read by dropping psel in ISSUE.
    @(posedge clk_i); #1;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = 14'h0008;
    @(posedge clk_i); #1;
    psel_i = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk_i); #1;
      if (pready_o) seen++;
    end
    checkOutput("abort_no_ready", seen, 32'd0);
    applyStimulus(1'b1, 14'h0010, 32'hA5A5A5A5, 4'hF, rd, err, waits);
    checkOutput("abort_recover", waits, 32'd1);

    // Reset in ISSUE of a write must cut the strobe immediately.
    @(posedge clk_i); #1;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = 14'h0014;
    pwdata_i = 32'h55AA55AA; pstrb_i = 4'hF;
    @(posedge clk_i); #1;
    checkOutput("we_in_issue", char_map_we_o, 32'd1);
    rst_i = 1'b0; psel_i = 1'b0;
    #1 checkOutput("we_cut", char_map_we_o, 32'd0);
    #2 rst_i = 1'b1;

    // Reset in CAPTURE clears the previously loaded prdata_o.
    applyStimulus(1'b0, 14'h095C, 32'h0, 4'h0, rd, err, waits);
    checkOutput("pre_capture_rd", prdata_o, 32'h11223344);
    @(posedge clk_i); #1;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = 14'h0008;
    @(posedge clk_i); #1;
    penable_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0; psel_i = 1'b0; penable_i = 1'b0;
    #1 checkOutput("capture_rst_prdata", prdata_o, 32'd0);
    checkOutput("capture_rst_ready", pready_o, 32'd0);
    #2 rst_i = 1'b1;
    repeat (2) @(posedge clk_i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
